// File: rtl/mem_read_arbiter_if.sv
// Bus bundle for mem_read_arbiter: two requester ports plus the engine's
// control and user-read sides. The arbiter takes the master view and the
// surrounding requesters/engine take the slave view.
interface mem_read_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Port 0: instruction fill
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_base;
  logic [ADDR_WIDTH-1:0] req0_length;
  logic                  req0_ready;
  logic                  req0_re;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_available;
  logic                  req0_done;

  // Port 1: data fill
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_base;
  logic [ADDR_WIDTH-1:0] req1_length;
  logic                  req1_ready;
  logic                  req1_re;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_available;
  logic                  req1_done;

  // Engine control and user-read stream
  logic [ADDR_WIDTH-1:0] mem_control_base;
  logic [ADDR_WIDTH-1:0] mem_control_length;
  logic                  mem_control_go;
  logic                  mem_control_done;
  logic                  mem_user_re;
  logic [DATA_WIDTH-1:0] mem_user_data;
  logic                  mem_user_available;

  modport master (
    input  req0_valid, req0_base, req0_length, req0_re,
    output req0_ready, req0_data, req0_available, req0_done,
    input  req1_valid, req1_base, req1_length, req1_re,
    output req1_ready, req1_data, req1_available, req1_done,
    output mem_control_base, mem_control_length, mem_control_go,
    input  mem_control_done,
    output mem_user_re,
    input  mem_user_data, mem_user_available
  );

  modport slave (
    output req0_valid, req0_base, req0_length, req0_re,
    input  req0_ready, req0_data, req0_available, req0_done,
    output req1_valid, req1_base, req1_length, req1_re,
    input  req1_ready, req1_data, req1_available, req1_done,
    input  mem_control_base, mem_control_length, mem_control_go,
    output mem_control_done,
    input  mem_user_re,
    output mem_user_data, mem_user_available
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one burst read engine between an
// instruction-fill port (0) and a data-fill port (1). Accepts a (base, length)
// request, kicks the engine, steers its read stream to the owner and pulses
// the owner's done once all words are delivered and the engine reports done.
module mem_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_read_arbiter_if.master bus,
  output logic               busy,
  output logic               grant
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_STREAM   = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_length;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_done_seen;

  logic                  w_sel_valid;
  logic                  w_sel;
  logic [ADDR_WIDTH-1:0] w_sel_base;
  logic [ADDR_WIDTH-1:0] w_sel_length;
  logic                  w_stream;
  logic                  w_room;
  logic                  w_grant_re;
  logic                  w_mem_re;
  logic                  w_fire;
  logic                  w_avail;
  logic                  w_exit;
  logic [DATA_WIDTH-1:0] w_data;

  // Arbitration in IDLE: a lone requester wins; a tie goes to the port that did not own the last burst.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = 1'b0;
    if (rst_n && (r_state == S_IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_sel_valid = 1'b1;
        w_sel       = ~r_last_grant;
      end else if (bus.req0_valid) begin
        w_sel_valid = 1'b1;
        w_sel       = 1'b0;
      end else if (bus.req1_valid) begin
        w_sel_valid = 1'b1;
        w_sel       = 1'b1;
      end
    end
  end

  assign w_sel_base   = w_sel ? bus.req1_base   : bus.req0_base;
  assign w_sel_length = w_sel ? bus.req1_length : bus.req0_length;

  // Stream steering; the word counter saturating at length blocks any overrun.
  assign w_stream   = (r_state == S_STREAM);
  assign w_room     = (r_count != r_length);
  assign w_grant_re = r_grant ? bus.req1_re : bus.req0_re;
  assign w_mem_re   = w_stream && w_grant_re && w_room;
  assign w_fire     = w_mem_re && bus.mem_user_available;
  assign w_avail    = w_stream && bus.mem_user_available && w_room;
  assign w_data     = w_stream ? bus.mem_user_data : '0;
  assign w_exit     = w_stream && !w_room && (r_done_seen || bus.mem_control_done);

  // Burst sequencer and captured burst context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_length     <= '0;
      r_count      <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_done_seen  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_grant     <= w_sel;
            r_base      <= w_sel_base;
            r_length    <= w_sel_length;
            r_count     <= '0;
            r_done_seen <= 1'b0;
            // A zero-length burst never touches the engine.
            r_state     <= (w_sel_length == '0) ? S_COMPLETE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_fire) begin
            r_count <= r_count + ADDR_WIDTH'(1);
          end
          if (bus.mem_control_done) begin
            r_done_seen <= 1'b1;
          end
          if (w_exit) begin
            r_state <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready     = w_sel_valid && !w_sel;
  assign bus.req1_ready     = w_sel_valid && w_sel;
  assign bus.req0_data      = r_grant ? '0 : w_data;
  assign bus.req1_data      = r_grant ? w_data : '0;
  assign bus.req0_available = w_avail && !r_grant;
  assign bus.req1_available = w_avail && r_grant;
  assign bus.req0_done      = (r_state == S_COMPLETE) && !r_grant;
  assign bus.req1_done      = (r_state == S_COMPLETE) && r_grant;

  assign bus.mem_control_base   = (r_state != S_IDLE) ? r_base   : '0;
  assign bus.mem_control_length = (r_state != S_IDLE) ? r_length : '0;
  assign bus.mem_control_go     = (r_state == S_ISSUE);
  assign bus.mem_user_re        = w_mem_re;

  assign busy  = (r_state != S_IDLE);
  assign grant = r_grant;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: two requester agents, a behavioural
// burst engine and a timestamp-based burst reference model.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NCYC = 4000;

  logic clk;
  logic rst_n;
  logic busy;
  logic grant;

  mem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;

  // Requester agents
  bit              a_pend [2];
  bit              a_lock [2];
  logic [AW-1:0]   a_base [2];
  int              a_len  [2];
  int              tie_at;
  bit              did_mid_reset;

  // Engine agent
  bit              e_busy;
  logic [AW-1:0]   e_base;
  int              e_idx;
  int              e_done_at;

  // Reference model: one burst record with timestamps
  bit              m_active;
  int              m_own;
  logic [AW-1:0]   m_base;
  int              m_len;
  int              m_got;
  bit              m_seen;
  int              m_accept;
  int              m_done_cyc;
  int              m_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] base, input int idx);
    return DW'(base) ^ (DW'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_own      = 0;
    m_base     = '0;
    m_len      = 0;
    m_got      = 0;
    m_seen     = 1'b0;
    m_accept   = 0;
    m_done_cyc = -1;
    m_last     = 1;
  endtask

  task automatic agents_reset();
    for (int p = 0; p < 2; p++) begin
      a_pend[p] = 1'b0;
      a_lock[p] = 1'b0;
    end
    e_busy    = 1'b0;
    e_idx     = 0;
    e_done_at = -1;
  endtask

  // Choose this cycle's requester and engine inputs.
  task automatic drive();
    if (cyc == tie_at) begin
      for (int p = 0; p < 2; p++) begin
        a_pend[p] = 1'b1;
        a_lock[p] = 1'b1;
        a_base[p] = AW'($urandom);
      end
      a_len[0] = 2;
      a_len[1] = 3;
    end else if (cyc > tie_at) begin
      for (int p = 0; p < 2; p++) begin
        if (a_pend[p]) begin
          if (!a_lock[p] && $urandom_range(0, 15) == 0) a_pend[p] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          a_pend[p] = 1'b1;
          a_base[p] = AW'($urandom);
          a_len[p]  = ($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(0, 6));
        end
      end
    end
    bus.req0_valid  = a_pend[0];
    bus.req0_base   = a_base[0];
    bus.req0_length = AW'(a_len[0]);
    bus.req1_valid  = a_pend[1];
    bus.req1_base   = a_base[1];
    bus.req1_length = AW'(a_len[1]);
    bus.req0_re     = ($urandom_range(0, 2) != 0);
    bus.req1_re     = ($urandom_range(0, 2) != 0);
    bus.mem_user_available = e_busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
    bus.mem_user_data      = e_busy ? word_of(e_base, e_idx) : DW'($urandom);
    bus.mem_control_done   = e_busy && (cyc == e_done_at);
  endtask

  // Compare DUT outputs against the model, then advance the model by one cycle.
  task automatic check_cycle();
    int win;
    bit stream;
    bit room;
    bit re_own;
    bit exp_re;
    bit exp_av;
    bit mav;
    bit mdone;
    win    = -1;
    mav    = bus.mem_user_available;
    mdone  = bus.mem_control_done;
    if (!m_active) begin
      if (bus.req0_valid && bus.req1_valid) win = 1 - m_last;
      else if (bus.req0_valid) win = 0;
      else if (bus.req1_valid) win = 1;
    end
    stream = m_active && (m_len != 0) && (cyc >= m_accept + 2) && (m_done_cyc < 0);
    room   = (m_got < m_len);
    re_own = (m_own == 1) ? bus.req1_re : bus.req0_re;
    exp_re = stream && re_own && room;
    exp_av = stream && mav && room;

    chk("ready0", 64'(bus.req0_ready), 64'(win == 0));
    chk("ready1", 64'(bus.req1_ready), 64'(win == 1));
    chk("busy", 64'(busy), 64'(m_active));
    if (m_active) chk("grant", 64'(grant), 64'(m_own));
    chk("go", 64'(bus.mem_control_go), 64'(m_active && m_len != 0 && cyc == m_accept + 1));
    chk("ctl_base", 64'(bus.mem_control_base), m_active ? 64'(m_base) : 64'd0);
    chk("ctl_len", 64'(bus.mem_control_length), m_active ? 64'(m_len) : 64'd0);
    chk("mem_re", 64'(bus.mem_user_re), 64'(exp_re));
    chk("avail0", 64'(bus.req0_available), 64'(exp_av && m_own == 0));
    chk("avail1", 64'(bus.req1_available), 64'(exp_av && m_own == 1));
    chk("data0", 64'(bus.req0_data), (stream && m_own == 0) ? 64'(bus.mem_user_data) : 64'd0);
    chk("data1", 64'(bus.req1_data), (stream && m_own == 1) ? 64'(bus.mem_user_data) : 64'd0);
    chk("done0", 64'(bus.req0_done), 64'(m_active && cyc == m_done_cyc && m_own == 0));
    chk("done1", 64'(bus.req1_done), 64'(m_active && cyc == m_done_cyc && m_own == 1));
    if (exp_re && mav)
      chk("word", 64'((m_own == 1) ? bus.req1_data : bus.req0_data), 64'(word_of(m_base, m_got)));

    if (win >= 0) begin
      m_active   = 1'b1;
      m_own      = win;
      m_base     = (win == 1) ? bus.req1_base : bus.req0_base;
      m_len      = (win == 1) ? a_len[1] : a_len[0];
      m_got      = 0;
      m_seen     = 1'b0;
      m_accept   = cyc;
      m_done_cyc = (m_len == 0) ? cyc + 1 : -1;
    end else if (m_active) begin
      if (cyc == m_done_cyc) begin
        m_active   = 1'b0;
        m_last     = m_own;
        m_done_cyc = -1;
      end else if (stream) begin
        if (!room && (m_seen || mdone)) m_done_cyc = cyc + 1;
        if (exp_re && mav) m_got++;
        if (mdone) m_seen = 1'b1;
      end
    end
  endtask

  // Agents react to what the DUT showed this cycle.
  task automatic observe();
    if (bus.req0_ready) begin a_pend[0] = 1'b0; a_lock[0] = 1'b0; end
    if (bus.req1_ready) begin a_pend[1] = 1'b0; a_lock[1] = 1'b0; end
    if (bus.mem_control_go) begin
      e_busy    = 1'b1;
      e_base    = bus.mem_control_base;
      e_idx     = 0;
      e_done_at = cyc + 1 + int'($urandom_range(0, 3 * int'(bus.mem_control_length) + 6));
    end else if (e_busy && bus.mem_user_re && bus.mem_user_available) begin
      e_idx++;
    end
    if (bus.req0_done || bus.req1_done) e_busy = 1'b0;
  endtask

  initial begin
    bit in_reset;
    bit post_reset;
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    tie_at        = 4;
    did_mid_reset = 1'b0;
    post_reset    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a_base[p] = '0;
      a_len[p]  = 0;
    end
    e_base = '0;
    agents_reset();
    model_reset();
    rst_n                  = 1'b0;
    bus.req0_valid         = 1'b0;
    bus.req0_base          = '0;
    bus.req0_length        = '0;
    bus.req0_re            = 1'b0;
    bus.req1_valid         = 1'b0;
    bus.req1_base          = '0;
    bus.req1_length        = '0;
    bus.req1_re            = 1'b0;
    bus.mem_control_done   = 1'b0;
    bus.mem_user_data      = '0;
    bus.mem_user_available = 1'b0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      in_reset = (cyc < 3);
      if (!did_mid_reset && cyc > 1500 && m_active && m_got >= 3 && m_got < m_len &&
          m_done_cyc < 0) begin
        did_mid_reset = 1'b1;
        in_reset      = 1'b1;
        tie_at        = cyc + 2;
      end
      rst_n = !in_reset;
      drive();
      @(negedge clk);
      if (in_reset) begin
        agents_reset();
        model_reset();
        post_reset = 1'b1;
      end else begin
        if (post_reset) begin
          chk("rst_grant", 64'(grant), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          post_reset = 1'b0;
        end
        check_cycle();
        observe();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one burst memory-read engine between two requesters: instruction fill (port 0) and data fill (port 1).
- Accepts a (base, length) burst request from either port and grants round-robin.
- Sequences the engine's control handshake (base/length/go/done) and steers the engine's user-side read stream to the granted requester only.
- Signals per-requester completion once all words are delivered and the engine reports done.

Parameters:
- ADDR_WIDTH, 32, width of base address, length and word counter (= `ADDR_WIDTH)
- DATA_WIDTH, 32, width of read data word (= `DATA_WIDTH)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  port 0 burst request; held until req0_ready
- req0_base  in  ADDR_WIDTH  port 0 burst start address
- req0_length  in  ADDR_WIDTH  port 0 burst length in words
- req0_ready  out  1  request accepted (one-cycle pulse)
- req0_re  in  1  port 0 read enable (consumes one word)
- req0_data  out  DATA_WIDTH  port 0 read data
- req0_available  out  1  word available to port 0
- req0_done  out  1  port 0 burst complete (one-cycle pulse)
- req1_*  same set as req0_*, for port 1
- mem_control_base  out  ADDR_WIDTH  to engine
- mem_control_length  out  ADDR_WIDTH  to engine
- mem_control_go  out  1  engine start pulse
- mem_control_done  in  1  engine completion pulse
- mem_user_re  out  1  engine read enable
- mem_user_data  in  DATA_WIDTH  engine read data
- mem_user_available  in  1  engine word available
- busy  out  1  high in any state other than IDLE
- grant  out  1  owning port (0/1); valid while busy

Behaviour:
- Reset (rst_n=0 at an edge, from any state, including mid-burst):
  - state=IDLE; counter=0; done_seen=0; last_grant=1, so port 0 wins the first tie.
  - All outputs 0.
  - The engine shares rst_n; no cleanup handshake is issued.
- States: IDLE, ISSUE, STREAM, COMPLETE.
- IDLE:
  - If exactly one reqN_valid is high, select that port.
  - If both are high, select the port != last_grant.
  - In the same cycle (Mealy): assert reqN_ready=1; register base, length and grant; clear counter and done_seen.
  - Next state is ISSUE, or COMPLETE if length==0. A zero-length burst never touches the engine.
- ISSUE:
  - mem_control_go=1 for exactly this cycle -> STREAM.
- Control outputs:
  - mem_control_base and mem_control_length are driven from registers, held stable from ISSUE until COMPLETE.
  - They are 0 in IDLE.
- STREAM:
  - mem_user_re = granted reqN_re AND (counter != length).
  - granted reqN_available = mem_user_available AND (counter != length).
  - granted reqN_data = mem_user_data; the non-granted port sees data=0, available=0, and its re is ignored.
  - counter increments on mem_user_re & mem_user_available; it saturates at length, so excess reads are blocked.
  - mem_control_done sets the sticky done_seen. done may arrive before, on, or after the last word.
  - Exit to COMPLETE in the first cycle where counter==length and (done_seen or mem_control_done).
- COMPLETE:
  - granted reqN_done=1 for one cycle; last_grant <= grant -> IDLE.
- Latency and throughput:
  - ready at cycle t, go at t+1.
  - One word per cycle while available & re.
  - done one cycle after the exit condition.
  - Minimum gap between the end of one burst and the next ready is 1 cycle (the IDLE cycle).
- Requests arriving while busy are held pending (valid held high) and are not acknowledged.
- A requester dropping valid before ready is legal; nothing is latched.
- Width: counter and length are unsigned ADDR_WIDTH; comparisons are equality only; no wrap is possible due to saturation.

Test Plan:
- Single burst: req0 base=0x100, len=4; engine supplies 4 words with re held 1 -> ready at t, go at t+1, data delivered to port 0 only, req0_done one cycle after the 4th word with done_seen; base/length stable throughout.
- Tie and round-robin:
  - Both valid at reset-exit -> port 0 granted first (len=2), then port 1 (len=3).
  - Both re-requested -> port 0 again.
  - Check grant, busy and done pulses; port 1 requests stall without ready while port 0 is busy.
- Zero length: req1 len=0 -> ready, no mem_control_go, req1_done on the next cycle, busy for exactly 1 cycle.
- Done ordering:
  - Engine pulses mem_control_done before the last of 8 words is consumed (re throttled 1-in-3) -> completes only after word 8.
  - Repeat with done 5 cycles after word 8 -> completes on the done cycle.
- Overrun and isolation:
  - Engine keeps available=1 after len=2 words -> mem_user_re forced 0, counter stays 2.
  - Non-granted req1_re=1 throughout -> no effect on the engine or the counter.
- Reset mid-STREAM after 3 of 6 words: rst_n=0 for one cycle -> all outputs 0 the next cycle, state IDLE; a subsequent simultaneous request grants port 0.
